// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and constants for the CPU front end
package cpu_pkg;

  // Fetch stage control states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    HOLD   = 2'd2,
    HALTED = 2'd3
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam int INST_W     = 32;
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int FUNC_MSB   = 5;
  localparam int FUNC_LSB   = 0;

  // Word-align an address by clearing the two byte-offset bits
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch stage: PC, imem handshake, decode output register
module inst_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [INST_W-1:0] dec_inst,
  output logic [5:0]        dec_opcode,
  output logic [5:0]        dec_func,
  output logic [ADDR_W-1:0] dec_pc4
);

  fetch_state_t      state, state_n;
  logic [ADDR_W-1:0] pc, pc_n;
  // addr is the address on the bus; it is frozen while a request is outstanding
  // so that a redirect only moves pc, not the in-flight request
  logic [ADDR_W-1:0] addr, addr_n;
  logic              kill, kill_n;
  logic              halt_pend, halt_pend_n;
  logic [INST_W-1:0] inst_q, inst_n;
  logic [ADDR_W-1:0] pc4_q, pc4_n;
  logic              xfer;
  logic [ADDR_W-1:0] target;

  assign xfer   = (state == REQ) && imem_ack;
  assign target = word_align(redirect_pc);

  // Next-state, PC and output-register update logic
  always_comb begin
    state_n     = state;
    pc_n        = pc;
    addr_n      = addr;
    kill_n      = kill;
    halt_pend_n = halt_pend;
    inst_n      = inst_q;
    pc4_n       = pc4_q;

    case (state)
      IDLE: begin
        if (halt) begin
          state_n = HALTED;
        end else begin
          if (redirect) pc_n = target;
          state_n = REQ;
        end
      end
      REQ: begin
        if (xfer) begin
          if (halt_pend || halt) begin
            // Outstanding request has drained; drop the word and stop
            state_n     = HALTED;
            halt_pend_n = 1'b0;
            kill_n      = 1'b0;
          end else if (kill || redirect) begin
            // Word belongs to a stale path; re-request from pc
            kill_n = 1'b0;
            if (redirect) pc_n = target;
          end else begin
            inst_n  = imem_rdata;
            pc4_n   = pc + ADDR_W'(4);
            pc_n    = pc + ADDR_W'(4);
            state_n = HOLD;
          end
        end else begin
          if (halt) halt_pend_n = 1'b1;
          if (redirect) begin
            pc_n   = target;
            kill_n = 1'b1;
          end
        end
      end
      HOLD: begin
        if (halt) begin
          state_n = HALTED;
        end else if (redirect) begin
          pc_n    = target;
          state_n = REQ;
        end else if (dec_ready) begin
          state_n = REQ;
        end
      end
      HALTED: begin
        state_n = HALTED;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    if (!((state == REQ) && !xfer)) addr_n = pc_n;
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      addr      <= RESET_PC;
      kill      <= 1'b0;
      halt_pend <= 1'b0;
      inst_q    <= '0;
      pc4_q     <= '0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      addr      <= addr_n;
      kill      <= kill_n;
      halt_pend <= halt_pend_n;
      inst_q    <= inst_n;
      pc4_q     <= pc4_n;
    end
  end

  assign imem_req   = (state == REQ);
  assign imem_addr  = addr;
  assign dec_valid  = (state == HOLD);
  assign dec_inst   = inst_q;
  assign dec_opcode = inst_q[OPCODE_MSB:OPCODE_LSB];
  assign dec_func   = inst_q[FUNC_MSB:FUNC_LSB];
  assign dec_pc4    = pc4_q;

endmodule
